// File: rtl/ppu_regfile_dma.sv
// CPU-side PPU register file ($2000-$2007 mirrored) with Loopy T/V, $2007 read buffer and $4014 OAM DMA.
// Latency: register reads are combinational; writes take effect on the next i_cpu_clk edge; DMA takes 513/514 cycles.
// Backpressure: o_cpu_halt stalls the CPU during DMA and bus accesses are ignored then. Optional open bus via PPU_OPENBUS_EN.
module ppu_regfile_dma #(
  parameter int          VRAM_AW      = 14,
  parameter int          OAM_AW       = 8,
  parameter logic [15:0] DMA_REG_ADDR = 16'h4014
) (
  input  logic               i_cpu_clk,
  input  logic               i_cpu_rstn,
  input  logic               i_bus_vld,
  input  logic [15:0]        i_bus_addr,
  input  logic               i_bus_wn,
  input  logic [7:0]         i_bus_wdata,
  output logic [7:0]         o_ppu_rdata,
  output logic               o_cpu_halt,
  output logic [15:0]        o_dma_addr,
  input  logic [7:0]         i_dma_rdata,
  output logic [OAM_AW-1:0]  o_oam_addr,
  output logic               o_oam_we,
  output logic [7:0]         o_oam_wdata,
  input  logic [7:0]         i_oam_rdata,
  output logic [VRAM_AW-1:0] o_vram_addr,
  output logic               o_vram_we,
  output logic [7:0]         o_vram_wdata,
  input  logic [7:0]         i_vram_rdata,
  output logic [14:0]        o_loopy_t,
  output logic [2:0]         o_fine_x,
  output logic [7:0]         o_ctrl,
  output logic [7:0]         o_mask,
  output logic               o_force_rld,
  input  logic               i_vblank,
  input  logic               i_spr_0hit,
  input  logic               i_spr_ovfl,
  output logic               o_nmi_n
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_RD    = 3'd3;
  localparam logic [2:0] S_WR    = 3'd4;

  logic [2:0]         r_state;
  logic [7:0]         r_page;
  logic [OAM_AW-1:0]  r_cnt;
  logic               r_par;
  logic [7:0]         r_ctrl;
  logic [7:0]         r_mask;
  logic               r_vflag;
  logic               r_vblank_d;
  logic [14:0]        r_t;
  logic [VRAM_AW-1:0] r_v;
  logic [2:0]         r_fine_x;
  logic               r_w;
  logic               r_rld_pend;
  logic [7:0]         r_rbuf;
  logic [OAM_AW-1:0]  r_oamaddr;

  logic               w_busy;
  logic               w_acc;
  logic               w_sel;
  logic [2:0]         w_reg;
  logic               w_rd;
  logic               w_wr;
  logic               w_dma_go;
  logic               w_rd2002;
  logic               w_pal;
  logic               w_vb_rise;
  logic               w_vb_fall;
  logic [VRAM_AW-1:0] w_step;
  logic [7:0]         w_rd_val;
  logic [4:0]         w_lo5;
  logic [7:0]         w_wo;

  assign w_busy    = (r_state != S_IDLE);
  assign w_acc     = i_bus_vld & ~w_busy;
  assign w_sel     = w_acc & (i_bus_addr[15:13] == 3'b001);
  assign w_reg     = i_bus_addr[2:0];
  assign w_rd      = w_sel & i_bus_wn;
  assign w_wr      = w_sel & ~i_bus_wn;
  assign w_dma_go  = w_acc & ~i_bus_wn & (i_bus_addr == DMA_REG_ADDR);
  assign w_rd2002  = w_rd & (w_reg == 3'd2);
  // Palette region is V[13:8]==$3F; VRAM_AW is expected to be at least 14.
  assign w_pal     = (r_v[13:8] == 6'h3F);
  assign w_vb_rise = i_vblank & ~r_vblank_d;
  assign w_vb_fall = ~i_vblank & r_vblank_d;
  assign w_step    = r_ctrl[2] ? VRAM_AW'(32) : VRAM_AW'(1);

`ifdef PPU_OPENBUS_EN
  logic [7:0]  r_ob;
  logic [19:0] r_decay;

  assign w_lo5 = r_ob[4:0];
  assign w_wo  = r_ob;

  // Open-bus latch refreshes on every PPU access and decays to 0 when left alone
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_ob    <= 8'h00;
      r_decay <= 20'd0;
    end else if (w_wr) begin
      r_ob    <= i_bus_wdata;
      r_decay <= 20'd0;
    end else if (w_rd) begin
      r_ob    <= w_rd_val;
      r_decay <= 20'd0;
    end else if (r_decay == 20'hFFFFF) begin
      r_ob    <= 8'h00;
    end else begin
      r_decay <= r_decay + 20'd1;
    end
  end
`else
  logic [7:0] r_lastwr;

  assign w_lo5 = r_lastwr[4:0];
  assign w_wo  = 8'h00;

  // Remember the last byte written to any PPU register for the PPUSTATUS low bits
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_lastwr <= 8'h00;
    else if (w_wr)   r_lastwr <= i_bus_wdata;
  end
`endif

  // Read data mux; write-only registers return the unimplemented-bit fill
  always_comb begin
    w_rd_val = w_wo;
    case (w_reg)
      3'd2:    w_rd_val = {r_vflag, i_spr_0hit, i_spr_ovfl, w_lo5};
      3'd4:    w_rd_val = i_oam_rdata;
      3'd7:    w_rd_val = w_pal ? i_vram_rdata : r_rbuf;
      default: w_rd_val = w_wo;
    endcase
  end

  assign o_ppu_rdata = w_rd ? w_rd_val : 8'h00;

  // Free-running parity decides whether DMA needs an alignment cycle
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) r_par <= 1'b0;
    else             r_par <= ~r_par;
  end

  // OAM DMA sequencer: one wait, optional align, then read/write pairs per byte
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_state <= S_IDLE;
      r_page  <= 8'h00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dma_go) begin
            r_page  <= i_bus_wdata;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT:  r_state <= r_par ? S_ALIGN : S_RD;
        S_ALIGN: r_state <= S_RD;
        S_RD:    r_state <= S_WR;
        S_WR: begin
          r_cnt   <= r_cnt + 1'b1;
          r_state <= (r_cnt == '1) ? S_IDLE : S_RD;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cpu_halt = w_busy;
  assign o_dma_addr = w_busy ? 16'({r_page, r_cnt}) : 16'h0000;

  // OAM address: CPU load via $2003, post-increment on $2004 writes and DMA writes
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn)                      r_oamaddr <= '0;
    else if (r_state == S_WR)             r_oamaddr <= r_oamaddr + 1'b1;
    else if (w_wr && (w_reg == 3'd3))     r_oamaddr <= OAM_AW'(i_bus_wdata);
    else if (w_wr && (w_reg == 3'd4))     r_oamaddr <= r_oamaddr + 1'b1;
  end

  assign o_oam_addr  = r_oamaddr;
  assign o_oam_we    = (r_state == S_WR) | (w_wr & (w_reg == 3'd4));
  assign o_oam_wdata = (r_state == S_WR)              ? i_dma_rdata :
                       (w_wr && (w_reg == 3'd4))      ? i_bus_wdata : 8'h00;

  // PPUCTRL / PPUMASK registers
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_ctrl <= 8'h00;
      r_mask <= 8'h00;
    end else if (w_wr) begin
      if (w_reg == 3'd0) r_ctrl <= i_bus_wdata;
      if (w_reg == 3'd1) r_mask <= i_bus_wdata;
    end
  end

  // Vblank flag: set on rising vblank (wins), cleared on falling vblank or after a $2002 read
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_vblank_d <= 1'b0;
      r_vflag    <= 1'b0;
    end else begin
      r_vblank_d <= i_vblank;
      if (w_vb_rise)                   r_vflag <= 1'b1;
      else if (w_vb_fall || w_rd2002)  r_vflag <= 1'b0;
    end
  end

  // Loopy T/V, write toggle, fine X and the $2007 read buffer
  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      r_t        <= 15'd0;
      r_v        <= '0;
      r_fine_x   <= 3'd0;
      r_w        <= 1'b0;
      r_rld_pend <= 1'b0;
      r_rbuf     <= 8'h00;
    end else begin
      r_rld_pend <= 1'b0;
      if (r_rld_pend)
        r_v <= VRAM_AW'(r_t);
      else if (w_sel && (w_reg == 3'd7))
        r_v <= r_v + w_step;
      if (w_rd && (w_reg == 3'd7))
        r_rbuf <= i_vram_rdata;
      if (w_rd2002)
        r_w <= 1'b0;
      if (w_wr) begin
        case (w_reg)
          3'd0: r_t[11:10] <= i_bus_wdata[1:0];
          3'd5: begin
            if (!r_w) begin
              r_t[4:0] <= i_bus_wdata[7:3];
              r_fine_x <= i_bus_wdata[2:0];
            end else begin
              r_t[9:5]   <= i_bus_wdata[7:3];
              r_t[14:12] <= i_bus_wdata[2:0];
            end
            r_w <= ~r_w;
          end
          3'd6: begin
            if (!r_w) begin
              r_t[13:8] <= i_bus_wdata[5:0];
              r_t[14]   <= 1'b0;
            end else begin
              r_t[7:0]   <= i_bus_wdata;
              r_rld_pend <= 1'b1;
            end
            r_w <= ~r_w;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_vram_addr  = r_v;
  assign o_vram_we    = w_wr & (w_reg == 3'd7);
  assign o_vram_wdata = o_vram_we ? i_bus_wdata : 8'h00;
  assign o_loopy_t    = r_t;
  assign o_fine_x     = r_fine_x;
  assign o_ctrl       = r_ctrl;
  assign o_mask       = r_mask;
  assign o_force_rld  = r_rld_pend;
  assign o_nmi_n      = ~(r_vflag & r_ctrl[7]);

endmodule
